// File: rtl/delay_ctrl.sv
// Pointer/sequencing controller for a RAM-backed variable delay line.
// Optional macro DELAY_CTRL_ERRCNT_EN adds the cfg_err_cnt output.
module delay_ctrl #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DEFAULT_DELAY = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  sclk,
    input  logic [ADDR_WIDTH-1:0] cfg_delay,
    input  logic                  cfg_req,
    output logic                  cfg_ack,
    output logic                  cfg_busy,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  out_valid,
    output logic                  bypass,
    output logic [ADDR_WIDTH-1:0] active_delay
`ifdef DELAY_CTRL_ERRCNT_EN
    ,
    output logic [7:0]            cfg_err_cnt
`endif
);

    localparam logic [ADDR_WIDTH-1:0] FILL_MAX = '1;
    localparam logic [ADDR_WIDTH-1:0] DEF_DLY  = ADDR_WIDTH'(DEFAULT_DELAY);

    typedef enum logic [1:0] {
        S_FILL,
        S_RUN,
        S_BYPASS
    } state_t;

    localparam state_t RST_STATE = (DEFAULT_DELAY == 0) ? S_BYPASS : S_FILL;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic [ADDR_WIDTH-1:0] act_q, act_d;
    logic                  pend_q, pend_d;
    logic [ADDR_WIDTH-1:0] pend_dly_q, pend_dly_d;
    logic                  ack_q, ack_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic                  ov_q, ov_d;
    logic                  byp_q, byp_d;
    logic                  apply;
    logic [ADDR_WIDTH-1:0] d_eff;
`ifdef DELAY_CTRL_ERRCNT_EN
    logic [7:0]            err_q, err_d;
`endif

    // Next-state: request latch, per-strobe apply, pointers and FSM.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        fill_d     = fill_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_dly_d = pend_dly_q;
        ack_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        ov_d       = ov_q;
        byp_d      = byp_q;
`ifdef DELAY_CTRL_ERRCNT_EN
        err_d      = err_q;
        if (cfg_req && pend_q && err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
        end
`endif
        // A request latched this cycle can only apply on a later strobe.
        apply = sclk && pend_q;
        d_eff = apply ? pend_dly_q : act_q;

        if (cfg_req && !pend_q) begin
            pend_d     = 1'b1;
            pend_dly_d = cfg_delay;
        end

        if (sclk) begin
            if (apply) begin
                act_d  = pend_dly_q;
                pend_d = 1'b0;
                ack_d  = 1'b1;
                if (d_eff == '0) begin
                    state_d = S_BYPASS;
                end else if (fill_q >= d_eff) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_FILL;
                end
            end else if (state_q == S_FILL && fill_q >= d_eff) begin
                state_d = S_RUN;
            end
            wr_en_d   = 1'b1;
            wr_addr_d = wr_ptr_q;
            rd_addr_d = wr_ptr_q - d_eff;
            rd_en_d   = (state_d != S_BYPASS);
            ov_d      = (state_d != S_FILL);
            byp_d     = (state_d == S_BYPASS);
            wr_ptr_d  = wr_ptr_q + 1'b1;
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= RST_STATE;
            wr_ptr_q   <= '0;
            fill_q     <= '0;
            act_q      <= DEF_DLY;
            pend_q     <= 1'b0;
            pend_dly_q <= '0;
            ack_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            ov_q       <= 1'b0;
            byp_q      <= (DEFAULT_DELAY == 0);
`ifdef DELAY_CTRL_ERRCNT_EN
            err_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            fill_q     <= fill_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_dly_q <= pend_dly_d;
            ack_q      <= ack_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            ov_q       <= ov_d;
            byp_q      <= byp_d;
`ifdef DELAY_CTRL_ERRCNT_EN
            err_q      <= err_d;
`endif
        end
    end

    assign cfg_ack      = ack_q;
    assign cfg_busy     = pend_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = rd_addr_q;
    assign out_valid    = ov_q;
    assign bypass       = byp_q;
    assign active_delay = act_q;
`ifdef DELAY_CTRL_ERRCNT_EN
    assign cfg_err_cnt  = err_q;
`endif

endmodule
